// File: rtl/aes_inv_round_ctrl_if.sv
// Block-level stream and key-store signals of the iterative AES-128 decryption sequencer.
// The slave modport is the sequencer's view; the master modport is the surrounding system.
interface aes_inv_round_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_block;
    logic [3:0]   key_idx;
    logic [0:127] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_block;
    logic         busy;

    modport slave (
        input  in_valid, in_block, round_key, out_ready,
        output in_ready, key_idx, out_valid, out_block, busy
    );

    modport master (
        output in_valid, in_block, round_key, out_ready,
        input  in_ready, key_idx, out_valid, out_block, busy
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128 decryption: one full inverse round per clock on a row-major 128-bit state,
// with round keys fetched combinationally from an external store selected by key_idx.
module aes_inv_round_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_inv_round_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [3:0]   round_cnt_reg, round_cnt_next;
    logic [0:127] state_reg, state_next;

    logic [0:127] isr;   // InvShiftRows(state)
    logic [0:127] isb;   // InvSubBytes(isr)
    logic [0:127] ark;   // isb ^ round_key
    logic [0:127] imc;   // MixColumnsInverse(ark)

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xt(sh);
        end
        return acc;
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_byte
            localparam int R  = gi / 4;
            localparam int C  = gi % 4;
            localparam int SC = (C - R + 4) % 4;
            assign isr[32*R + 8*C +: 8] = state_reg[32*R + 8*SC +: 8];
            assign isb[32*R + 8*C +: 8] = inv_sbox(isr[32*R + 8*C +: 8]);
        end
    endgenerate

    assign ark = isb ^ bus.round_key;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[     8*gi +: 8];
            assign a1 = ark[32 + 8*gi +: 8];
            assign a2 = ark[64 + 8*gi +: 8];
            assign a3 = ark[96 + 8*gi +: 8];
            assign imc[     8*gi +: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            assign imc[32 + 8*gi +: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            assign imc[64 + 8*gi +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            assign imc[96 + 8*gi +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            round_cnt_reg <= 4'd0;
            state_reg     <= '0;
        end else begin
            fsm_reg       <= fsm_next;
            round_cnt_reg <= round_cnt_next;
            state_reg     <= state_next;
        end
    end

    always_comb begin
        fsm_next       = fsm_reg;
        round_cnt_next = round_cnt_reg;
        state_next     = state_reg;
        bus.in_ready   = 1'b0;
        bus.out_valid  = 1'b0;
        bus.busy       = 1'b0;
        bus.key_idx    = 4'd10;
        bus.out_block  = '0;
        case (fsm_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    // Initial AddRoundKey uses key 10, presented while idle.
                    state_next     = bus.in_block ^ bus.round_key;
                    round_cnt_next = 4'd9;
                    fsm_next       = ROUND;
                end
            end
            ROUND: begin
                bus.busy    = 1'b1;
                bus.key_idx = round_cnt_reg;
                state_next  = imc;
                if (round_cnt_reg == 4'd1) fsm_next = FINAL;
                else                       round_cnt_next = round_cnt_reg - 4'd1;
            end
            FINAL: begin
                bus.busy    = 1'b1;
                bus.key_idx = 4'd0;
                state_next  = ark;
                fsm_next    = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                bus.out_block = state_reg;
                if (bus.out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: ciphertexts come from a forward AES-128 model, and a cycle-timeline
// model predicts every handshake output; FIPS-197 vectors pin the model itself.
module tb_aes_inv_round_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    aes_inv_round_ctrl_if bus();
    aes_inv_round_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [7:0]   sbox [256];
    logic [0:127] rk [0:10];
    logic [0:127] cur_pt = '0;
    int           m_cnt = 0;     // cycles since accept; 0 = idle, 1..10 = computing, 11 = holding
    logic [0:127] m_pt = '0;

    always @(posedge clk) cyc <= cyc + 1;
    assign bus.round_key = rk[bus.key_idx];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = '0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS byte string (byte k = row k%4, column k/4) to the row-major bus layout.
    function automatic logic [0:127] fips2rm(input logic [127:0] v);
        logic [0:127] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[32*r + 8*c +: 8] = v[127 - 8*(4*c + r) -: 8];
        return o;
    endfunction

    task automatic expand_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k <= 10; k++)
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    rk[k][32*r + 8*c +: 8] = w[4*k + c][31 - 8*r -: 8];
    endtask

    function automatic logic [0:127] encrypt(input logic [0:127] pt);
        logic [0:127] s;
        logic [0:127] t;
        logic [7:0]   a [4];
        s = pt ^ rk[0];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[32*r + 8*c +: 8] = sbox[s[32*r + 8*((c + r) % 4) +: 8]];
            if (rd != 10)
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = t[32*i + 8*c +: 8];
                    for (int i = 0; i < 4; i++)
                        t[32*i + 8*c +: 8] = gmul(8'h02, a[i]) ^ gmul(8'h03, a[(i+1)%4]) ^ a[(i+2)%4] ^ a[(i+3)%4];
                end
            s = t ^ rk[rd];
        end
        return s;
    endfunction

    // Per-cycle compare against the timeline model, then advance the model for the coming edge.
    always @(negedge clk) begin
        int c;
        logic [6:0]   exp_ctl;
        logic [0:127] exp_out;
        c = rst_n ? m_cnt : 0;
        exp_ctl = {c == 0, (c >= 1 && c <= 10), c == 11,
                   ((c == 0 || c == 11) ? 4'd10 : 4'(10 - c))};
        exp_out = (c == 11) ? m_pt : '0;
        chk("ctl {in_ready,busy,out_valid,key_idx}",
            {bus.in_ready, bus.busy, bus.out_valid, bus.key_idx}, exp_ctl);
        chk("out_block", bus.out_block, exp_out);
        if (!rst_n) m_cnt <= 0;
        else if (m_cnt == 0) begin
            if (bus.in_valid) begin
                m_cnt <= 1;
                m_pt  <= cur_pt;
            end
        end else if (m_cnt < 11) m_cnt <= m_cnt + 1;
        else if (bus.out_ready) m_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [0:127] ct, input logic [0:127] pt, input int bp,
                        input bit churn, input string tag);
        int n;
        logic [0:127] got;
        bus.in_block  = ct;
        cur_pt        = pt;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 50) begin tick(); n++; end
        chk({tag, " accept wait"}, 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            if (churn) bus.in_block = rnd128();
            tick();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(10));
        got = bus.out_block;
        chk({tag, " plaintext"}, got, pt);
        repeat (bp) tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, " in_ready after release"}, 128'(bus.in_ready), 128'(1));
        $display("block %s ct=%h pt=%h got=%h backpressure=%0d churn=%0d", tag, ct, pt, got, bp, churn);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:127] pa, pb, ca, cb;
        int n, t0, t1;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;
        build_sbox();
        chk("sbox[00]", 128'(sbox[8'h00]), 128'(8'h63));
        chk("sbox[53]", 128'(sbox[8'h53]), 128'(8'hed));
        expand_key(128'h000102030405060708090a0b0c0d0e0f);

        #1 rst_n = 1'b0;
        #1;
        chk("reset ctl", {bus.in_ready, bus.busy, bus.out_valid, bus.key_idx}, {1'b1, 1'b0, 1'b0, 4'd10});
        chk("reset out_block", bus.out_block, '0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 C.1
        pa = fips2rm(128'h00112233445566778899aabbccddeeff);
        ca = fips2rm(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        chk("model C.1 encrypt", encrypt(pa), ca);
        send(ca, pa, 0, 1'b0, "C.1");

        // FIPS-197 B, with 20 cycles of back-pressure
        expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
        pb = fips2rm(128'h3243f6a8885a308d313198a2e0370734);
        cb = fips2rm(128'h3925841d02dc09fbdc118597196a0b32);
        chk("model B encrypt", encrypt(pb), cb);
        send(cb, pb, 20, 1'b0, "B");

        // Back-to-back: a block occupies IDLE, nine ROUND, FINAL and one HOLD cycle
        pa = rnd128(); pb = rnd128();
        ca = encrypt(pa); cb = encrypt(pb);
        bus.out_ready = 1'b1;
        bus.in_block  = ca; cur_pt = pa;
        bus.in_valid  = 1'b1;
        t0 = cyc;
        tick();
        bus.in_block = cb; cur_pt = pb;
        n = 0;
        while (!bus.in_ready && n < 40) begin tick(); n++; end
        t1 = cyc;
        tick();
        bus.in_valid = 1'b0;
        bus.in_block = rnd128();
        chk("b2b accept spacing", 128'(t1 - t0), 128'(12));
        n = 0;
        while (!bus.out_valid && n < 40) begin tick(); n++; end
        chk("b2b second latency", 128'(n), 128'(10));
        tick();
        bus.out_ready = 1'b0;
        $display("block b2b pt0=%h pt1=%h spacing=%0d", pa, pb, t1 - t0);

        // Reset five cycles after accept
        pa = rnd128(); ca = encrypt(pa);
        bus.in_block = ca; cur_pt = pa; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midop reset ctl", {bus.in_ready, bus.busy, bus.out_valid, bus.key_idx}, {1'b1, 1'b0, 1'b0, 4'd10});
        chk("midop reset out_block", bus.out_block, '0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (15) tick();
        $display("block reset-abort pt=%h discarded", pa);
        pa = rnd128();
        send(encrypt(pa), pa, 1, 1'b0, "after-reset");

        // Input churn after accept
        pa = rnd128();
        send(encrypt(pa), pa, 0, 1'b1, "churn");

        // Random keys and blocks
        for (int k = 0; k < 6; k++) begin
            expand_key(rnd128());
            pa = rnd128();
            send(encrypt(pa), pa, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "random");
        end

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
